// File: rtl/pc_unit_pkg.sv
// Shared types and constants for the fetch-side PC unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_unit_pkg;

    // One-hot-free 2-bit state encoding; all four codes are meaningful.
    typedef enum logic [1:0] {
        S_BOOT  = 2'b00,
        S_RUN   = 2'b01,
        S_HALT  = 2'b10,
        S_FAULT = 2'b11
    } pc_state_t;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] COUNT_MAX        = 32'hFFFF_FFFF;

    // A fetch address is legal only when word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_branch_unit_if.sv
// Bundle of control inputs and PC/status outputs of the PC unit.
// Latency: n/a (wiring only).
// Backpressure: Stall input holds the PC; no ready signal back to the decoder.
interface pc_branch_unit_if;

    logic        Stall;
    logic        Branch;
    logic        Zero;
    logic        Jump;
    logic        Halt;
    logic [31:0] SignImmShifted;
    logic [25:0] InstrIdx;

    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [31:0] PCBranch;
    logic        InstrValid;
    logic        Halted;
    logic        Fault;
    logic [31:0] TakenCount;

    // Decode/ALU side: drives control, observes PC and status.
    modport master (
        output Stall, Branch, Zero, Jump, Halt, SignImmShifted, InstrIdx,
        input  PC, PCPlus4, PCBranch, InstrValid, Halted, Fault, TakenCount
    );

    // PC unit side.
    modport slave (
        input  Stall, Branch, Zero, Jump, Halt, SignImmShifted, InstrIdx,
        output PC, PCPlus4, PCBranch, InstrValid, Halted, Fault, TakenCount
    );

endinterface

// File: rtl/pc_next_mux.sv
// Next-PC datapath: PC+4, branch target, jump target, priority select, alignment flag.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the selected target is committed.
module pc_next_mux
    import pc_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] sign_imm_shifted,
    input  logic [25:0] instr_idx,
    input  logic        jump,
    input  logic        take_branch,
    output logic [31:0] pc_plus4,
    output logic [31:0] pc_branch,
    output logic [31:0] target,
    output logic        misaligned
);

    logic [31:0] pc_jump;

    // Adders wrap modulo 2^32; the carry out is intentionally dropped.
    always_comb begin
        pc_plus4  = pc + PC_STEP;
        pc_branch = pc_plus4 + sign_imm_shifted;
        pc_jump   = {pc_plus4[31:28], instr_idx, 2'b00};
    end

    // Jump beats a taken branch, which beats sequential fetch.
    always_comb begin
        target = pc_plus4;
        if (jump) begin
            target = pc_jump;
        end else if (take_branch) begin
            target = pc_branch;
        end
        misaligned = is_misaligned(target);
    end

endmodule

// File: rtl/pc_branch_unit.sv
// Fetch PC register with next-PC select and BOOT/RUN/HALT/FAULT fetch-gating FSM.
// Latency: selected target appears on PC one edge later; PCPlus4/PCBranch follow PC combinationally.
// Backpressure: Stall holds PC and suppresses fault check and counting; Halt overrides Stall.
// Optional taken-branch counter enabled by defining PC_BRANCH_STATS_EN.
module pc_branch_unit
    import pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int unsigned BOOT_CYCLES = 2
)(
    input  logic             clk,
    input  logic             reset,
    pc_branch_unit_if.slave  pc_bus
);

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    pc_state_t   state;
    pc_state_t   state_next;
    logic [3:0]  boot_cnt;
    logic [3:0]  boot_cnt_next;
    logic [31:0] pc_q;
    logic [31:0] pc_next;

    logic        take_branch;
    logic [31:0] target;
    logic        misaligned;

    assign take_branch = pc_bus.Branch & pc_bus.Zero;

    pc_next_mux u_next_mux (
        .pc               (pc_q),
        .sign_imm_shifted (pc_bus.SignImmShifted),
        .instr_idx        (pc_bus.InstrIdx),
        .jump             (pc_bus.Jump),
        .take_branch      (take_branch),
        .pc_plus4         (pc_bus.PCPlus4),
        .pc_branch        (pc_bus.PCBranch),
        .target           (target),
        .misaligned       (misaligned)
    );

    // State, boot counter and PC registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_BOOT;
            boot_cnt <= 4'd0;
            pc_q     <= RESET_PC;
        end else begin
            state    <= state_next;
            boot_cnt <= boot_cnt_next;
            pc_q     <= pc_next;
        end
    end

    // Next state and PC; inputs are only honoured while running.
    always_comb begin
        state_next    = state;
        boot_cnt_next = boot_cnt;
        pc_next       = pc_q;
        unique case (state)
            S_BOOT: begin
                if (boot_cnt == BOOT_LAST) begin
                    state_next = S_RUN;
                end else begin
                    boot_cnt_next = boot_cnt + 4'd1;
                end
            end
            S_RUN: begin
                if (pc_bus.Halt) begin
                    state_next = S_HALT;
                end else if (!pc_bus.Stall) begin
                    if (misaligned) begin
                        state_next = S_FAULT;
                    end else begin
                        pc_next = target;
                    end
                end
            end
            S_HALT, S_FAULT: begin
                state_next = state;
            end
            default: begin
                state_next = S_BOOT;
            end
        endcase
    end

    assign pc_bus.PC         = pc_q;
    assign pc_bus.InstrValid = (state == S_RUN);
    assign pc_bus.Halted     = (state == S_HALT);
    assign pc_bus.Fault      = (state == S_FAULT);

`ifdef PC_BRANCH_STATS_EN
    logic [31:0] taken_cnt;
    logic        count_en;

    // A taken branch counts only when it actually commits a new PC.
    assign count_en = (state == S_RUN) & ~pc_bus.Halt & ~pc_bus.Stall
                    & ~misaligned & take_branch & ~pc_bus.Jump;

    // Saturating taken-branch counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taken_cnt <= 32'd0;
        end else if (count_en && taken_cnt != COUNT_MAX) begin
            taken_cnt <= taken_cnt + 32'd1;
        end
    end

    assign pc_bus.TakenCount = taken_cnt;
`else
    assign pc_bus.TakenCount = 32'h0;
`endif

endmodule
